serializer_lane_scheduler: RTL
==============================

Name: serializer_lane_scheduler

Overview:
- Time-division scheduler that shares one 8:1 tree serializer lane between NUM_REQ word sources.
- Divides time into fixed slots of WORD_CYCLES clocks, one serializer word per slot.
- At each slot boundary it grants one requester, round-robin. Periodically it inserts a SYNC_WORD for receiver alignment; when no requester is valid it inserts IDLE_WORD.
- PAR_OUT drives the serializer PAR_IN and is held stable for a whole slot.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WORD_CYCLES, 8, clocks per slot; must match serializer shift length (>=2).
- SYNC_INTERVAL, 4, slots between sync words; 0 disables sync insertion.
- SYNC_WORD, 8'hA5, alignment word.
- IDLE_WORD, 8'h00, filler word when no grant.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  slot timer run enable.
- REQ_VALID  in  NUM_REQ  per-requester word available.
- REQ_DATA  in  NUM_REQ*8  requester i data at [8i+7:8i].
- REQ_READY  out  NUM_REQ  one-hot accept; word transfers when VALID&READY.
- PAR_OUT  out  8  word to serializer PAR_IN.
- WORD_STROBE  out  1  high in first cycle of each new slot.
- SLOT_VALID  out  1  current slot carries requester data.
- SLOT_OWNER  out  clog2(NUM_REQ)  index of current slot owner.
- SYNC_FLAG  out  1  current slot is a sync slot.

Behaviour:
- Reset, asynchronous: PAR_OUT=IDLE_WORD, WORD_STROBE=0, SLOT_VALID=0, SLOT_OWNER=0, SYNC_FLAG=0.
- Reset internal state: cnt=0; rr_last=NUM_REQ-1 so requester 0 has first priority; wcnt=SYNC_INTERVAL so the first slot is a sync slot when sync is enabled.
- Slot timer, ENABLE=1: cnt counts 0..WORD_CYCLES-1 and wraps.
- Slot timer, ENABLE=0: cnt is forced to 0 and no decision is made. On the next edge PAR_OUT=IDLE_WORD and SLOT_VALID=SYNC_FLAG=WORD_STROBE=0. wcnt and rr_last are held.
- Decision cycle: ENABLE=1 and cnt==WORD_CYCLES-1. The first decision after reset falls WORD_CYCLES-1 enabled cycles after reset deassert.
- Priority at a decision, highest first:
  1. Sync due (SYNC_INTERVAL!=0 and wcnt==SYNC_INTERVAL): next slot is SYNC_WORD, SYNC_FLAG=1, SLOT_VALID=0, wcnt<=0, REQ_READY all 0, rr_last unchanged.
  2. Else round-robin: search REQ_VALID starting at rr_last+1 mod NUM_REQ. The first valid index w wins. REQ_READY[w]=1 combinationally in this cycle only. Next slot: PAR_OUT=REQ_DATA[w] sampled this cycle, SLOT_VALID=1, SLOT_OWNER=w, rr_last<=w, wcnt<=wcnt+1.
  3. Else no valid requester: next slot is IDLE_WORD, SLOT_VALID=0, SLOT_OWNER holds, wcnt<=wcnt+1.
- wcnt counts data and idle slots alike. wcnt saturation is not needed: the counter wraps only via the sync path. With SYNC_INTERVAL=0, wcnt is unused and held at 0.
- REQ_READY is 0 outside decision cycles and is never multi-hot. It depends combinationally on REQ_VALID (no requester may wait for READY before asserting VALID).
- A requester dropping VALID before the decision cycle is simply skipped; there is no latching of earlier VALID.
- WORD_STROBE=1 exactly in the cycle with cnt==0 following a decision; otherwise 0.
- PAR_OUT, SLOT_*, SYNC_FLAG change only on the edge after a decision, on the edge after ENABLE=0, or on reset.
- Latency: request accepted in decision cycle -> on PAR_OUT at the next edge -> held WORD_CYCLES clocks.
- RESET mid-slot: the slot is aborted immediately, outputs take reset values, and the sync-first sequence restarts.
- ENABLE re-asserted: the slot timer restarts from cnt=0, so the first decision is WORD_CYCLES-1 cycles later.

Test Plan:
Defaults for all scenarios: NUM_REQ=4, WORD_CYCLES=8, SYNC_INTERVAL=4.
1. All four VALID with data 11,22,33,44 held -> slot sequence A5,11,22,33,44,A5,11. REQ_READY pulses 0,1,2,3 on cnt==7. WORD_STROBE every 8 cycles. SYNC_FLAG high only on A5 slots.
2. Only requester 2 valid, data 5C -> A5,5C,5C,5C,5C,A5. SLOT_OWNER=2 and SLOT_VALID=1 on data slots.
3. Requesters 1 and 3 valid -> grants alternate 1,3,1,3 across sync slots; rr_last is preserved over sync.
4. No VALID -> A5 then 00 slots with SLOT_VALID=0 and REQ_READY never asserted. Asserting VALID[0] mid-slot -> granted at the next cnt==7 only.
5. ENABLE dropped at cnt==3 of a data slot -> next cycle PAR_OUT=00, SLOT_VALID=0. Re-enable -> the first decision occurs 7 cycles later with the wcnt sequence continuing.
6. RESET pulsed at cnt==5 while requester 0 is granted -> outputs immediately at reset values. After release with ENABLE=1, the first slot is A5 and the next grant goes to requester 0.

Source files
------------

// File: rtl/serializer_lane_scheduler.sv
// Round-robin time-division scheduler feeding one 8:1 serializer lane.
// One word per WORD_CYCLES-clock slot, with periodic sync and idle fill.
module serializer_lane_scheduler #(
  parameter int          NUM_REQ       = 4,
  parameter int          WORD_CYCLES   = 8,
  parameter int          SYNC_INTERVAL = 4,
  parameter logic [7:0]  SYNC_WORD     = 8'hA5,
  parameter logic [7:0]  IDLE_WORD     = 8'h00
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [NUM_REQ*8-1:0]       REQ_DATA,
  output logic [NUM_REQ-1:0]         REQ_READY,
  output logic [7:0]                 PAR_OUT,
  output logic                       WORD_STROBE,
  output logic                       SLOT_VALID,
  output logic [$clog2(NUM_REQ)-1:0] SLOT_OWNER,
  output logic                       SYNC_FLAG
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WORD_CYCLES);
  localparam int WW = (SYNC_INTERVAL > 0) ?
                      $clog2(SYNC_INTERVAL + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_CYCLES - 1);
  localparam logic [WW-1:0] WCNT_TOP = WW'(SYNC_INTERVAL);
  localparam logic [OW-1:0] RR_INIT  = OW'(NUM_REQ - 1);

  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic [OW-1:0] rr_last;

  logic          decide;
  logic          sync_due;
  logic          found;
  logic          grant;
  logic [OW-1:0] win;
  logic [OW-1:0] idx;
  logic [7:0]    win_data;

  assign decide   = ENABLE && (cnt == CNT_LAST);
  assign sync_due = (SYNC_INTERVAL != 0) && (wcnt == WCNT_TOP);

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = OW'((int'(rr_last) + off) % NUM_REQ);
      if (!found && REQ_VALID[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant    = decide && !sync_due && found;
  assign win_data = REQ_DATA[{win, 3'b000} +: 8];

  always_comb begin
    REQ_READY = '0;
    if (grant)
      REQ_READY[win] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt         <= '0;
      wcnt        <= WCNT_TOP;
      rr_last     <= RR_INIT;
      PAR_OUT     <= IDLE_WORD;
      WORD_STROBE <= 1'b0;
      SLOT_VALID  <= 1'b0;
      SLOT_OWNER  <= '0;
      SYNC_FLAG   <= 1'b0;
    end else if (!ENABLE) begin
      cnt         <= '0;
      PAR_OUT     <= IDLE_WORD;
      WORD_STROBE <= 1'b0;
      SLOT_VALID  <= 1'b0;
      SYNC_FLAG   <= 1'b0;
    end else begin
      WORD_STROBE <= decide;
      cnt         <= decide ? '0 : cnt + CW'(1);
      if (decide) begin
        if (sync_due) begin
          PAR_OUT    <= SYNC_WORD;
          SYNC_FLAG  <= 1'b1;
          SLOT_VALID <= 1'b0;
          wcnt       <= '0;
        end else begin
          SYNC_FLAG <= 1'b0;
          // wcnt stays parked at 0 when sync insertion is off.
          if (SYNC_INTERVAL != 0)
            wcnt <= wcnt + WW'(1);
          if (found) begin
            PAR_OUT    <= win_data;
            SLOT_VALID <= 1'b1;
            SLOT_OWNER <= win;
            rr_last    <= win;
          end else begin
            PAR_OUT    <= IDLE_WORD;
            SLOT_VALID <= 1'b0;
          end
        end
      end
    end
  end

endmodule
